// File: rtl/ldo_pkg.sv
// Shared definitions for the leading-one scanner: FSM encoding and position width helper.
package ldo_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_e;

   // Enough bits to hold every position 0..WIDTH-1 plus the "no bit set" code WIDTH.
   function automatic int pos_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/ldo_lzc.sv
// Combinational leading-one locator, MSB-first positions, built as a binary tree of depth clog2(WIDTH).
module ldo_lzc
   import ldo_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int POS_W = pos_w(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [POS_W-1:0] pos,
   output logic [WIDTH-1:0] onehot
);

   localparam int LVL = $clog2(WIDTH);
   localparam int P   = 1 << LVL;

   // Level 0 holds the input in MSB-first order, zero-padded at the LSB end to a power of two.
   // Each tree node reports "any bit set" and the offset of its leading one within its span.
   for (genvar l = 0; l <= LVL; l++) begin : g_lvl
      localparam int N = P >> l;
      logic [N-1:0] v;
      if (l == 0) begin : g_leaf
         for (genvar i = 0; i < N; i++) begin : g_bit
            if (i < WIDTH) begin : g_in
               assign v[i] = vec[WIDTH-1-i];
            end else begin : g_pad
               assign v[i] = 1'b0;
            end
         end
      end else begin : g_node
         logic [N-1:0][l-1:0] p;
         for (genvar n = 0; n < N; n++) begin : g_n
            assign v[n] = g_lvl[l-1].v[2*n] | g_lvl[l-1].v[2*n+1];
            if (l == 1) begin : g_base
               assign p[n] = ~g_lvl[l-1].v[2*n];
            end else begin : g_merge
               assign p[n] = g_lvl[l-1].v[2*n] ? {1'b0, g_lvl[l-1].g_node.p[2*n]}
                                               : {1'b1, g_lvl[l-1].g_node.p[2*n+1]};
            end
         end
      end
   end

   logic           any;
   logic [LVL-1:0] top_p;

   assign any   = g_lvl[LVL].v[0];
   assign top_p = g_lvl[LVL].g_node.p[0];
   assign pos   = any ? POS_W'(top_p) : POS_W'(WIDTH);

   for (genvar j = 0; j < WIDTH; j++) begin : g_oh
      assign onehot[j] = any & (top_p == LVL'(WIDTH - 1 - j));
   end

endmodule

// File: rtl/ldo_scan.sv
// Sequential leading-one scanner: accepts a word, then reports its set bits MSB first, one per beat.
module ldo_scan
   import ldo_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int POS_W = pos_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_first_only,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] out_pos,
   output logic             out_last
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // out_valid never depends on out_ready, and out_pos/out_last hold while stalled.

   state_e           state;
   logic [WIDTH-1:0] residual;
   logic             mode;

   logic [POS_W-1:0] lz_pos;
   logic [WIDTH-1:0] lz_onehot;
   logic [WIDTH-1:0] cleared;
   logic             last_raw;
   logic             out_fire;
   logic             in_fire;

   ldo_lzc #(.WIDTH(WIDTH)) u_lzc (
      .vec    (residual),
      .pos    (lz_pos),
      .onehot (lz_onehot)
   );

   assign cleared   = residual & ~lz_onehot;
   assign last_raw  = (cleared == '0) | mode | (residual == '0);

   assign out_valid = (state == ST_SCAN);
   assign out_pos   = out_valid ? lz_pos : '0;
   assign out_last  = out_valid & last_raw;

   assign out_fire  = out_valid & out_ready;
   assign in_ready  = (state == ST_IDLE) | (out_fire & out_last);
   assign in_fire   = in_valid & in_ready;

   // A word accepted on the final beat reloads in place, so the next word has no idle bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         residual <= '0;
         mode     <= 1'b0;
      end else if (in_fire) begin
         state    <= ST_SCAN;
         residual <= in_data;
         mode     <= in_first_only;
      end else if (out_fire) begin
         residual <= cleared;
         if (out_last) begin
            state <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_ldo_scan.sv
// Directed bench for ldo_scan: queue model of expected beats checked every cycle plus literal beat lists.
module tb_ldo_scan;

   localparam int W   = 32;
   localparam int PW  = 6;
   localparam int W8  = 8;
   localparam int PW8 = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_first_only = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [PW-1:0] out_pos;
   logic          out_last;

   logic           s_in_valid = 1'b0;
   logic           s_in_ready;
   logic [W8-1:0]  s_in_data = '0;
   logic           s_in_first_only = 1'b0;
   logic           s_out_valid;
   logic           s_out_ready = 1'b1;
   logic [PW8-1:0] s_out_pos;
   logic           s_out_last;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [PW:0] exp_q[$];
   logic [PW:0] log_q[$];
   int          stamp_q[$];

   ldo_scan #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first_only(in_first_only),
      .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos), .out_last(out_last)
   );

   ldo_scan #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_first_only(s_in_first_only),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pos(s_out_pos), .out_last(s_out_last)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cycle);
      end
   endtask

   function automatic logic [PW:0] b(input logic last, input int pos);
      return {last, PW'(pos)};
   endfunction

   // Model: a word produces the MSB-first list of its set positions (or 32 when zero).
   task automatic model_push(input logic [W-1:0] d, input logic fo);
      int pl[$];
      for (int i = 0; i < W; i++) if (d[W-1-i]) pl.push_back(i);
      if (pl.size() == 0) exp_q.push_back(b(1'b1, W));
      else if (fo) exp_q.push_back(b(1'b1, pl[0]));
      else foreach (pl[k]) exp_q.push_back(b(k == pl.size() - 1, pl[k]));
   endtask

   // Scoreboard compare process, sampled on the falling edge.
   always @(negedge clk) begin
      logic fire_m;
      logic exp_rdy;
      if (rst) begin
         exp_q.delete();
      end else begin
         fire_m  = (exp_q.size() > 0) && out_ready;
         exp_rdy = (exp_q.size() == 0) || (fire_m && exp_q[0][PW]);
         chk("out_valid", out_valid, exp_q.size() > 0);
         chk("in_ready", in_ready, exp_rdy);
         if (exp_q.size() > 0) begin
            chk("out_pos", out_pos, exp_q[0][PW-1:0]);
            chk("out_last", out_last, exp_q[0][PW]);
         end else begin
            chk("idle_pos", out_pos, 0);
            chk("idle_last", out_last, 0);
         end
         if (out_valid && out_ready) begin
            log_q.push_back({out_last, out_pos});
            stamp_q.push_back(cycle);
         end
         if (fire_m) void'(exp_q.pop_front());
         if (in_valid && exp_rdy) model_push(in_data, in_first_only);
      end
   end

   // Driver tasks: called just after a rising edge, return just after the accepting edge.
   task automatic send(input logic [W-1:0] d, input logic fo);
      int n = 0;
      in_valid = 1'b1;
      in_data = d;
      in_first_only = fo;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 1, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data = $urandom_range(0, 32'hFFFF);
      in_first_only = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((out_valid || exp_q.size() != 0) && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (out_valid) chk("wait_idle_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_q.delete();
      stamp_q.delete();
   endtask

   task automatic check_log(input string name, input int n, input logic [PW:0] e[4], input logic gapless);
      chk({name, "_count"}, log_q.size(), n);
      for (int i = 0; i < n && i < log_q.size(); i++) begin
         chk({name, "_beat"}, log_q[i], e[i]);
         if (gapless && i > 0) chk({name, "_gap"}, stamp_q[i] - stamp_q[i-1], 1);
      end
   endtask

   task automatic check8(input string name, input logic v, input int pos, input logic last);
      @(negedge clk);
      chk({name, "_valid"}, s_out_valid, v);
      chk({name, "_pos"}, s_out_pos, pos);
      chk({name, "_last"}, s_out_last, last);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_valid", out_valid, 0);
      chk("reset_ready", in_ready, 1);
      chk("reset_pos", out_pos, 0);
      chk("reset_ready8", s_in_ready, 1);
      @(posedge clk);
      #1;

      // Zero word: one beat at position 32
      clear_log();
      send(32'h0000_0000, 1'b0);
      wait_idle();
      check_log("zero", 1, '{b(1, 32), 0, 0, 0}, 1'b1);

      // All-mode scan
      clear_log();
      send(32'h1880_0000, 1'b0);
      wait_idle();
      check_log("all", 3, '{b(0, 3), b(0, 4), b(1, 8), 0}, 1'b1);

      // First-only mode
      clear_log();
      send(32'h00FF_000D, 1'b1);
      wait_idle();
      send(32'h0000_000A, 1'b1);
      wait_idle();
      check_log("first", 2, '{b(1, 8), b(1, 28), 0, 0}, 1'b0);

      // Backpressure holds the current beat
      clear_log();
      out_ready = 1'b0;
      send(32'h0000_000A, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_pos", out_pos, 28);
         chk("bp_last", out_last, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_idle();
      check_log("bp", 2, '{b(0, 28), b(1, 30), 0, 0}, 1'b1);

      // Back-to-back words with no bubble
      clear_log();
      send(32'h8000_0001, 1'b0);
      send(32'h4000_0000, 1'b0);
      wait_idle();
      check_log("b2b", 3, '{b(0, 0), b(1, 31), b(1, 1), 0}, 1'b1);

      // Reset during the second beat
      clear_log();
      send(32'hF000_0000, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_ready", in_ready, 1);
      check_log("rst_mid", 1, '{b(0, 0), 0, 0, 0}, 1'b0);
      @(posedge clk);
      #1;
      clear_log();
      send(32'hF000_0000, 1'b0);
      wait_idle();
      check_log("rescan", 4, '{b(0, 0), b(0, 1), b(0, 2), b(1, 3)}, 1'b1);

      // WIDTH=8 instance
      s_in_valid = 1'b1;
      s_in_data  = 8'h81;
      @(negedge clk);
      chk("w8_ready", s_in_ready, 1);
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      check8("w8_b0", 1'b1, 0, 1'b0);
      check8("w8_b1", 1'b1, 7, 1'b1);
      check8("w8_idle", 1'b0, 0, 1'b0);
      @(posedge clk);
      #1;
      s_in_valid = 1'b1;
      s_in_data  = 8'h00;
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      check8("w8_zero", 1'b1, 8, 1'b1);
      check8("w8_zero_idle", 1'b0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
